multiword_add_seq: RTL and testbench

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

---
 rtl/add_pkg.sv | 12 +
 rtl/adder_8bit_ripple.sv | 21 ++
 rtl/multiword_add_seq.sv | 144 ++++++++++++++
 tb/tb_multiword_add_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and constants for the sequential multi-word adder.
package add_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/adder_8bit_ripple.sv
// Combinational 8-bit ripple-carry adder used as the per-slice arithmetic unit.
module adder_8bit_ripple (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    always_comb begin : ripple
        logic w_c;
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < 8; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one 8-bit slice per cycle through a single ripple adder.
// Define MWADD_OVERFLOW_EN to add the registered signed-overflow output ovf.
module multiword_add_seq
    import add_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*NWORDS-1:0]   a,
    input  logic [SLICE_W*NWORDS-1:0]   b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*NWORDS-1:0]   sum,
    output logic                        cout
`ifdef MWADD_OVERFLOW_EN
    ,
    output logic                        ovf
`endif
);

    localparam int W     = SLICE_W * NWORDS;
    localparam int IDX_W = $clog2(NWORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [SLICE_W-1:0] w_aSlice;
    logic [SLICE_W-1:0] w_bSlice;
    logic [SLICE_W-1:0] w_sliceSum;
    logic               w_sliceCout;
    logic               w_lastSlice;
`ifdef MWADD_OVERFLOW_EN
    logic               r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                if (w_lastSlice) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_lastSlice = (r_idx == LAST_IDX);

    // Select the operand slices addressed by the current index for the shared adder.
    always_comb begin
        w_aSlice = '0;
        w_bSlice = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (r_idx == i[IDX_W-1:0]) begin
                w_aSlice = r_a[i*SLICE_W +: SLICE_W];
                w_bSlice = r_b[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder_8bit_ripple u_adder (
        .i_a    (w_aSlice),
        .i_b    (w_bSlice),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_cout (w_sliceCout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef MWADD_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
`ifdef MWADD_OVERFLOW_EN
                        r_ovf   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (r_idx == i[IDX_W-1:0]) r_sum[i*SLICE_W +: SLICE_W] <= w_sliceSum;
                    end
                    r_carry <= w_sliceCout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_lastSlice) begin
                        r_cout <= w_sliceCout;
`ifdef MWADD_OVERFLOW_EN
                        // Carry into the MSB is recovered from the MSB sum bit.
                        r_ovf  <= w_sliceCout ^ (w_aSlice[SLICE_W-1] ^ w_bSlice[SLICE_W-1] ^ w_sliceSum[SLICE_W-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef MWADD_OVERFLOW_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (NWORDS=4 and NWORDS=1 instances)
// against an arithmetic reference model; ovf checked when MWADD_OVERFLOW_EN is defined.
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [31:0] a, b, sum;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
    logic [7:0]  a1, b1, sum1;
`ifdef MWADD_OVERFLOW_EN
    logic        ovf, ovf1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiword_add_seq #(.NWORDS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef MWADD_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    multiword_add_seq #(.NWORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef MWADD_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width unsigned add for sum/cout, signed add range check for overflow.
    function automatic void refAdd(input logic [31:0] x, input logic [31:0] y, input logic c,
                                   output logic [31:0] s, output logic co, output logic ov);
        longint unsigned t;
        longint          sx, sy, st;
        t  = longint'(x) + longint'(y) + longint'(c);
        s  = t[31:0];
        co = t[32];
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        st = sx + sy + longint'(c);
        ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    endfunction

    task automatic applyStimulus(input logic [31:0] xa, input logic [31:0] xb, input logic xc, input int hold);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        refAdd(xa, xb, xc, es, ec, eo);
        @(posedge clk); #1;
        checkOutput("in_ready_idle", in_ready, 1);
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, 4);
        checkOutput("sum", sum, es);
        checkOutput("cout", cout, ec);
`ifdef MWADD_OVERFLOW_EN
        checkOutput("ovf", ovf, eo);
`endif
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_sum", sum, es);
            checkOutput("hold_cout", cout, ec);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("post_hs_out_valid", out_valid, 0);
        checkOutput("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_cout", cout, 0);

        applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        applyStimulus(32'h12345678, 32'h00000000, 1'b1, 0);
        applyStimulus(32'h89ABCDEF, 32'h76543210, 1'b1, 5);
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 0);

        // Reset lands while slice 2 is being processed; the aborted add must never show.
        @(posedge clk); #1;
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_sum", sum, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_cout", cout, 0);
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= out_valid; end
        checkOutput("midrst_no_pulse", seen, 0);
        applyStimulus(32'h00000003, 32'h00000004, 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Single-slice instance.
        @(posedge clk); #1;
        checkOutput("n1_in_ready", in_ready1, 1);
        a1 = 8'hF0; b1 = 8'h20; cin1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        checkOutput("n1_valid_early", out_valid1, 0);
        @(posedge clk); #1;
        checkOutput("n1_out_valid", out_valid1, 1);
        checkOutput("n1_sum", sum1, 8'h10);
        checkOutput("n1_cout", cout1, 1);
`ifdef MWADD_OVERFLOW_EN
        checkOutput("n1_ovf", ovf1, 0);
`endif
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        checkOutput("n1_post_hs_ready", in_ready1, 1);
        checkOutput("n1_post_hs_valid", out_valid1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
